// File: rtl/lsu_multicycle_pkg.sv
// Shared types for the multicycle load/store unit: access sizes and FSM states.
package lsu_multicycle_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE__BYTE   = 2'b00,
    MEM_SIZE__HALF   = 2'b01,
    MEM_SIZE__WORD   = 2'b10,
    MEM_SIZE__DOUBLE = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU__IDLE   = 2'b00,
    LSU__ACCESS = 2'b01,
    LSU__DONE   = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/lsu_multicycle_if.sv
// Memory-side req/ack bus of the load/store unit; master is the LSU, slave is the memory.
interface lsu_multicycle_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_multicycle_lane_align.sv
// Combinational lane steering: byte enables, shifted store data, extended load data
// and the misalignment / illegal-size flag.
module lsu_lane_align
  import lsu_multicycle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  mem_size_t           size,
  input  logic [OFF_W-1:0]    offset,
  input  logic                unsigned_ld,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [BE_W-1:0]     mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   ld_data,
  output logic                misalign
);

  logic [BE_W-1:0]   be_base;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign_bit;

  // A full-width access has an all-ones mask, so the extension term vanishes and
  // unsigned_ld has no effect there.
  always_comb begin
    be_base  = '1;
    mask     = '1;
    shifted  = mem_rdata >> {offset, 3'b000};
    sign_bit = shifted[DATA_W-1];
    misalign = 1'b0;
    case (size)
      MEM_SIZE__BYTE: begin
        be_base  = BE_W'(1);
        mask     = DATA_W'(8'hFF);
        sign_bit = shifted[7];
      end
      MEM_SIZE__HALF: begin
        be_base  = BE_W'(2'b11);
        mask     = DATA_W'(16'hFFFF);
        sign_bit = shifted[15];
        misalign = offset[0];
      end
      MEM_SIZE__WORD: begin
        be_base  = BE_W'(4'hF);
        mask     = DATA_W'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
        misalign = (offset & OFF_W'(3)) != '0;
      end
      default: begin
        misalign = (DATA_W == 32) || (offset != '0);
      end
    endcase
    mem_be    = be_base << offset;
    mem_wdata = wdata << {offset, 3'b000};
    ld_data   = (shifted & mask) | ((!unsigned_ld && sign_bit) ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit with req/ack memory handshake.
// Optional macro LSU_TIMEOUT_EN adds a TIMEOUT-cycle ack watchdog.
module lsu_multicycle
  import lsu_multicycle_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  mem_size_t           size,
  input  logic                unsigned_ld,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  lsu_multicycle_if.master    mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_t          state_q, state_d;
  logic                we_q, uns_q, err_q;
  mem_size_t           size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;

  logic                in_idle, in_access, accept, timed_out;
  mem_size_t           la_size;
  logic [OFF_W-1:0]    la_offset;
  logic                la_uns;
  logic [DATA_W-1:0]   la_wdata;
  logic [BE_W-1:0]     la_be;
  logic [DATA_W-1:0]   la_wdata_sh, la_ld_data;
  logic                la_misalign;

  assign in_idle   = (state_q == LSU__IDLE);
  assign in_access = (state_q == LSU__ACCESS);
  assign accept    = in_idle && req;

  // In IDLE the aligner sees the live request so misalignment is caught before
  // acceptance; afterwards it sees the latched request.
  assign la_size   = in_idle ? size                : size_q;
  assign la_offset = in_idle ? addr[OFF_W-1:0]     : addr_q[OFF_W-1:0];
  assign la_uns    = in_idle ? unsigned_ld         : uns_q;
  assign la_wdata  = in_idle ? wdata               : wdata_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size        (la_size),
    .offset      (la_offset),
    .unsigned_ld (la_uns),
    .wdata       (la_wdata),
    .mem_rdata   (mem.mem_rdata),
    .mem_be      (la_be),
    .mem_wdata   (la_wdata_sh),
    .ld_data     (la_ld_data),
    .misalign    (la_misalign)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!in_access) begin
      wait_cnt <= '0;
    end else if (!mem.mem_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // An ack in the final allowed cycle still wins over the watchdog.
  assign timed_out = in_access && !mem.mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LSU__IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU__IDLE:   if (req) state_d = la_misalign ? LSU__DONE : LSU__ACCESS;
      LSU__ACCESS: if (mem.mem_ack || timed_out) state_d = LSU__DONE;
      LSU__DONE:   state_d = LSU__IDLE;
      default:     state_d = LSU__IDLE;
    endcase
  end

  // Request latch, error flag and load result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= MEM_SIZE__BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        uns_q   <= unsigned_ld;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= la_misalign;
        if (la_misalign) rdata_q <= '0;
      end
      if (in_access) begin
        if (mem.mem_ack) begin
          err_q <= 1'b0;
          if (!we_q) rdata_q <= la_ld_data;
        end else if (timed_out) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign ready         = in_idle;
  assign done          = (state_q == LSU__DONE);
  assign err           = done && err_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = in_access;
  assign mem.mem_we    = in_access && we_q;
  assign mem.mem_be    = in_access ? la_be : '0;
  assign mem.mem_addr  = in_access ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem.mem_wdata = (in_access && we_q) ? la_wdata_sh : '0;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Directed self-checking bench for lsu_multicycle (DATA_W=32, TIMEOUT=4).
module tb_lsu_multicycle;
  import lsu_multicycle_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  mem_size_t   size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  lsu_multicycle_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  lsu_multicycle #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; on return the accepting edge has passed.
  task automatic apply_stimulus(input logic s_we, input mem_size_t s_size,
                                input logic s_uns, input logic [31:0] s_addr,
                                input logic [31:0] s_wdata);
    req         = 1'b1;
    we          = s_we;
    size        = s_size;
    unsigned_ld = s_uns;
    addr        = s_addr;
    wdata       = s_wdata;
    tick();
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; size = MEM_SIZE__BYTE; unsigned_ld = 1'b0;
    addr = '0; wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    tick(); tick();
    check_output("rst_ready", ready, 1);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_mem_req", mem_bus.mem_req, 0);
    check_output("rst_mem_be", mem_bus.mem_be, 0);
    check_output("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();

    $display("[TB] LB sign-extended at 0x103");
    apply_stimulus(1'b0, MEM_SIZE__BYTE, 1'b0, 32'h103, 32'h0);
    check_output("lb_mem_req", mem_bus.mem_req, 1);
    check_output("lb_mem_addr", mem_bus.mem_addr, 32'h100);
    check_output("lb_mem_be", mem_bus.mem_be, 4'b1000);
    check_output("lb_mem_we", mem_bus.mem_we, 0);
    check_output("lb_ready", ready, 0);
    check_output("lb_early_done", done, 0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h80FF_FF12;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("lb_done", done, 1);
    check_output("lb_err", err, 0);
    check_output("lb_rdata", rdata, 32'hFFFF_FF80);
    check_output("lb_req_drop", mem_bus.mem_req, 0);
    tick();
    check_output("lb_idle_ready", ready, 1);
    check_output("lb_done_pulse", done, 0);

    $display("[TB] LHU at 0x202");
    apply_stimulus(1'b0, MEM_SIZE__HALF, 1'b1, 32'h202, 32'h0);
    check_output("lhu_mem_be", mem_bus.mem_be, 4'b1100);
    check_output("lhu_mem_addr", mem_bus.mem_addr, 32'h200);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hBEEF_1234;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("lhu_done", done, 1);
    check_output("lhu_rdata", rdata, 32'h0000_BEEF);
    tick();

    $display("[TB] stray ack in IDLE");
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("stray_ack_ready", ready, 1);
    check_output("stray_ack_done", done, 0);

    $display("[TB] SB at 0x001 with 3 wait cycles");
    apply_stimulus(1'b1, MEM_SIZE__BYTE, 1'b0, 32'h001, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      check_output("sb_wait_mem_req", mem_bus.mem_req, 1);
      check_output("sb_wait_mem_we", mem_bus.mem_we, 1);
      check_output("sb_wait_mem_be", mem_bus.mem_be, 4'b0010);
      check_output("sb_wait_mem_wdata", mem_bus.mem_wdata, 32'h0000_AB00);
      check_output("sb_wait_done", done, 0);
      if (i == 1) begin
        req = 1'b1; we = 1'b0; addr = 32'h3FC;
      end
      tick();
      req = 1'b0;
    end
    check_output("sb_ignored_req_addr", mem_bus.mem_addr, 32'h000);
    check_output("sb_ignored_req_we", mem_bus.mem_we, 1);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("sb_done", done, 1);
    check_output("sb_err", err, 0);
    check_output("sb_rdata_kept", rdata, 32'h0000_BEEF);
    tick();

    $display("[TB] LW misaligned at 0x006");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h006, 32'h0);
    check_output("lw_mis_done", done, 1);
    check_output("lw_mis_err", err, 1);
    check_output("lw_mis_mem_req", mem_bus.mem_req, 0);
    check_output("lw_mis_rdata", rdata, 0);
    tick();
    check_output("lw_mis_ready", ready, 1);

    $display("[TB] double size illegal on 32-bit bus");
    apply_stimulus(1'b0, MEM_SIZE__DOUBLE, 1'b0, 32'h000, 32'h0);
    check_output("ld_illegal_done", done, 1);
    check_output("ld_illegal_err", err, 1);
    tick();

    $display("[TB] LH sign-extended at 0x000");
    apply_stimulus(1'b0, MEM_SIZE__HALF, 1'b0, 32'h000, 32'h0);
    check_output("lh_mem_be", mem_bus.mem_be, 4'b0011);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_8001;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("lh_err", err, 0);
    check_output("lh_rdata", rdata, 32'hFFFF_8001);
    tick();

    $display("[TB] reset during ACCESS");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h010, 32'h0);
    check_output("rst_mid_mem_req_pre", mem_bus.mem_req, 1);
    check_output("rst_mid_mem_addr_pre", mem_bus.mem_addr, 32'h010);
    #2 reset = 1'b1;
    #1;
    check_output("rst_mid_mem_req", mem_bus.mem_req, 0);
    check_output("rst_mid_ready", ready, 1);
    check_output("rst_mid_mem_be", mem_bus.mem_be, 0);
    check_output("rst_mid_mem_addr", mem_bus.mem_addr, 0);
    check_output("rst_mid_rdata", rdata, 0);
    check_output("rst_mid_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] back-to-back LW");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h020, 32'h0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    req = 1'b1; addr = 32'h040;
    tick();
    mem_bus.mem_ack = 1'b0; req = 1'b0;
    check_output("b2b_first_done", done, 1);
    check_output("b2b_first_rdata", rdata, 32'h1234_5678);
    check_output("b2b_done_ready", ready, 0);
    tick();
    check_output("b2b_idle_ready", ready, 1);
    check_output("b2b_no_queued_req", mem_bus.mem_req, 0);
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h030, 32'h0);
    check_output("b2b_second_mem_req", mem_bus.mem_req, 1);
    check_output("b2b_second_addr", mem_bus.mem_addr, 32'h030);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("b2b_second_done", done, 1);
    check_output("b2b_second_rdata", rdata, 32'hCAFE_F00D);
    tick();

`ifdef LSU_TIMEOUT_EN
    $display("[TB] timeout with no ack");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h050, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_output("to_mem_req_held", mem_bus.mem_req, 1);
      tick();
    end
    check_output("to_done", done, 1);
    check_output("to_err", err, 1);
    check_output("to_mem_req_drop", mem_bus.mem_req, 0);
    check_output("to_rdata", rdata, 0);
    tick();

    $display("[TB] ack on the last allowed cycle");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h054, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_output("to_ack_mem_req_held", mem_bus.mem_req, 1);
      tick();
    end
    check_output("to_ack_last_mem_req", mem_bus.mem_req, 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("to_ack_done", done, 1);
    check_output("to_ack_err", err, 0);
    check_output("to_ack_rdata", rdata, 32'h1111_2222);
    tick();
`else
    $display("[TB] long wait without watchdog");
    apply_stimulus(1'b0, MEM_SIZE__WORD, 1'b0, 32'h050, 32'h0);
    for (int i = 0; i < 20; i++) begin
      check_output("nowd_mem_req_held", mem_bus.mem_req, 1);
      check_output("nowd_no_done", done, 0);
      tick();
    end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
    tick();
    mem_bus.mem_ack = 1'b0;
    check_output("nowd_done", done, 1);
    check_output("nowd_err", err, 0);
    check_output("nowd_rdata", rdata, 32'h1111_2222);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
